// File: rtl/wb_width_bridge_pkg.sv
// Shared definitions for the Wishbone width bridge: FSM state encoding and
// byte-order helpers applied to 32-bit words and their 4-bit selects.
package wb_width_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic [31:0] endian_x32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [3:0] endian_x4(input logic [3:0] s);
    return {s[0], s[1], s[2], s[3]};
  endfunction

endpackage

// File: rtl/wb_lane_steer.sv
// Combinational lane placement (32-bit word -> bus lane) and extraction
// (bus lane -> 32-bit word), each with optional byte reversal.
module wb_lane_steer #(
  parameter int WB_DWIDTH   = 32,
  parameter int ENDIAN_SWAP = 1
) (
  input  logic [1:0]             lane,
  input  logic [31:0]            word_in,
  input  logic [3:0]             sel_in,
  input  logic [WB_DWIDTH-1:0]   bus_in,
  output logic [WB_DWIDTH-1:0]   bus_out,
  output logic [WB_DWIDTH/8-1:0] sel_out,
  output logic [31:0]            word_out
);
  import wb_width_bridge_pkg::*;

  localparam int NW = WB_DWIDTH / 32;

  logic [1:0]  lane_eff;
  logic [31:0] word_sw;
  logic [3:0]  sel_sw;
  logic [31:0] rd_word;

  // Lane bits beyond the bus width are ignored, so a 32-bit bus always uses lane 0.
  assign lane_eff = lane & 2'(NW - 1);
  assign word_sw  = (ENDIAN_SWAP != 0) ? endian_x32(word_in) : word_in;
  assign sel_sw   = (ENDIAN_SWAP != 0) ? endian_x4(sel_in) : sel_in;

  always_comb begin
    bus_out = '0;
    sel_out = '0;
    rd_word = '0;
    for (int i = 0; i < NW; i++) begin
      if (lane_eff == 2'(i)) begin
        bus_out[32*i +: 32] = word_sw;
        sel_out[4*i +: 4]   = sel_sw;
        rd_word             = bus_in[32*i +: 32];
      end
    end
  end

  assign word_out = (ENDIAN_SWAP != 0) ? endian_x32(rd_word) : rd_word;

endmodule

// File: rtl/wb_width_bridge.sv
// Registered 32-bit master to WB_DWIDTH system-bus bridge, one transaction in flight.
// Optional downstream timeout abort is built when WB_BRIDGE_TIMEOUT_EN is defined.
module wb_width_bridge #(
  parameter int WB_DWIDTH      = 32,
  parameter int WB_SWIDTH      = WB_DWIDTH / 8,
  parameter int ENDIAN_SWAP    = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [31:0]          i_m_wb_adr,
  input  logic [3:0]           i_m_wb_sel,
  input  logic                 i_m_wb_we,
  input  logic [31:0]          i_m_wb_wdat,
  input  logic                 i_m_wb_cyc,
  input  logic                 i_m_wb_stb,
  output logic [31:0]          o_m_wb_rdat,
  output logic                 o_m_wb_ack,
  output logic                 o_m_wb_err,
  output logic [31:0]          o_s_wb_adr,
  output logic [WB_SWIDTH-1:0] o_s_wb_sel,
  output logic                 o_s_wb_we,
  output logic [WB_DWIDTH-1:0] o_s_wb_wdat,
  output logic                 o_s_wb_cyc,
  output logic                 o_s_wb_stb,
  input  logic [WB_DWIDTH-1:0] i_s_wb_rdat,
  input  logic                 i_s_wb_ack,
  input  logic                 i_s_wb_err,
  output logic                 o_timeout
);
  import wb_width_bridge_pkg::*;

  if (!(WB_DWIDTH == 32 || WB_DWIDTH == 64 || WB_DWIDTH == 128) ||
      WB_SWIDTH != WB_DWIDTH / 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("wb_width_bridge: illegal parameter set");
  end

  logic [1:0]           state;
  logic                 aborted;
  logic                 s_done;
  logic                 s_ok;
  logic                 m_gone;
  logic                 tmo_hit;
  logic [WB_SWIDTH-1:0] req_sel;
  logic [WB_DWIDTH-1:0] req_wdat;
  logic [31:0]          rsp_word;
  logic [31:0]          req_word_unused;
  logic [WB_DWIDTH-1:0] rsp_bus_unused;
  logic [WB_SWIDTH-1:0] rsp_sel_unused;

  wb_lane_steer #(.WB_DWIDTH(WB_DWIDTH), .ENDIAN_SWAP(ENDIAN_SWAP)) u_req_steer (
    .lane     (i_m_wb_adr[3:2]),
    .word_in  (i_m_wb_wdat),
    .sel_in   (i_m_wb_sel),
    .bus_in   ('0),
    .bus_out  (req_wdat),
    .sel_out  (req_sel),
    .word_out (req_word_unused)
  );

  // Read lane comes from the registered address, which is stable throughout REQ.
  wb_lane_steer #(.WB_DWIDTH(WB_DWIDTH), .ENDIAN_SWAP(ENDIAN_SWAP)) u_rsp_steer (
    .lane     (o_s_wb_adr[3:2]),
    .word_in  ('0),
    .sel_in   ('0),
    .bus_in   (i_s_wb_rdat),
    .bus_out  (rsp_bus_unused),
    .sel_out  (rsp_sel_unused),
    .word_out (rsp_word)
  );

  assign s_done = i_s_wb_ack | i_s_wb_err;
  assign s_ok   = i_s_wb_ack & ~i_s_wb_err;
  assign m_gone = aborted | ~i_m_wb_cyc;

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt;

  // A slave response in the final count cycle wins over the timeout.
  assign tmo_hit = (state == ST_REQ) && !s_done &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt   <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= tmo_hit;
      if (state == ST_REQ) tmo_cnt <= tmo_cnt + 1'b1;
      else                 tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      aborted     <= 1'b0;
      o_s_wb_adr  <= '0;
      o_s_wb_sel  <= '0;
      o_s_wb_we   <= 1'b0;
      o_s_wb_wdat <= '0;
      o_s_wb_cyc  <= 1'b0;
      o_s_wb_stb  <= 1'b0;
      o_m_wb_rdat <= '0;
      o_m_wb_ack  <= 1'b0;
      o_m_wb_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_m_wb_cyc && i_m_wb_stb) begin
            o_s_wb_adr  <= i_m_wb_adr;
            o_s_wb_sel  <= req_sel;
            o_s_wb_we   <= i_m_wb_we;
            o_s_wb_wdat <= req_wdat;
            o_s_wb_cyc  <= 1'b1;
            o_s_wb_stb  <= 1'b1;
            aborted     <= 1'b0;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!i_m_wb_cyc) aborted <= 1'b1;
          if (s_done || tmo_hit) begin
            o_s_wb_cyc <= 1'b0;
            o_s_wb_stb <= 1'b0;
            // An abandoned master gets no response; the slave cycle has still closed.
            if (m_gone) begin
              state <= ST_IDLE;
            end else begin
              state       <= ST_RESP;
              o_m_wb_ack  <= s_ok;
              o_m_wb_err  <= ~s_ok;
              o_m_wb_rdat <= s_ok ? rsp_word : 32'h0;
            end
          end
        end
        ST_RESP: begin
          o_m_wb_ack <= 1'b0;
          o_m_wb_err <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_width_bridge.sv
// Directed bench for wb_width_bridge at 128-bit width with byte swapping.
// Covers the WB_BRIDGE_TIMEOUT_EN build (TIMEOUT_CYCLES=8) and the default build.
module tb_wb_width_bridge;
  localparam int DW = 128;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   m_adr = '0;
  logic [3:0]    m_sel = '0;
  logic          m_we = 1'b0;
  logic [31:0]   m_wdat = '0;
  logic          m_cyc = 1'b0;
  logic          m_stb = 1'b0;
  logic [31:0]   m_rdat;
  logic          m_ack;
  logic          m_err;
  logic [31:0]   s_adr;
  logic [SW-1:0] s_sel;
  logic          s_we;
  logic [DW-1:0] s_wdat;
  logic          s_cyc;
  logic          s_stb;
  logic [DW-1:0] s_rdat = '0;
  logic          s_ack = 1'b0;
  logic          s_err = 1'b0;
  logic          tmo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_width_bridge #(
    .WB_DWIDTH(DW), .WB_SWIDTH(SW), .ENDIAN_SWAP(1), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m_wb_adr(m_adr), .i_m_wb_sel(m_sel), .i_m_wb_we(m_we), .i_m_wb_wdat(m_wdat),
    .i_m_wb_cyc(m_cyc), .i_m_wb_stb(m_stb),
    .o_m_wb_rdat(m_rdat), .o_m_wb_ack(m_ack), .o_m_wb_err(m_err),
    .o_s_wb_adr(s_adr), .o_s_wb_sel(s_sel), .o_s_wb_we(s_we), .o_s_wb_wdat(s_wdat),
    .o_s_wb_cyc(s_cyc), .o_s_wb_stb(s_stb),
    .i_s_wb_rdat(s_rdat), .i_s_wb_ack(s_ack), .i_s_wb_err(s_err),
    .o_timeout(tmo)
  );

  task automatic drive_req(input logic [31:0] adr, input logic [3:0] sel,
                           input logic we, input logic [31:0] wdat);
    m_adr = adr; m_sel = sel; m_we = we; m_wdat = wdat;
    m_cyc = 1'b1; m_stb = 1'b1;
  endtask

  task automatic master_idle();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_sel = '0; m_wdat = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin errors++; $display("FAIL reset_s_ctl got=%b exp=000", {s_cyc, s_stb, s_we}); end
    checks++; if (s_adr !== 32'h0 || s_sel !== 16'h0) begin errors++; $display("FAIL reset_s_adr_sel got=%h/%h exp=0/0", s_adr, s_sel); end
    checks++; if (s_wdat !== '0) begin errors++; $display("FAIL reset_s_wdat got=%h exp=0", s_wdat); end
    checks++; if ({m_ack, m_err, tmo} !== 3'b000 || m_rdat !== 32'h0) begin errors++; $display("FAIL reset_m_out got=%b rdat=%h exp=000 rdat=0", {m_ack, m_err, tmo}, m_rdat); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_lane();
    logic [DW-1:0] exp_wdat;
    exp_wdat = {32'h0, 32'h4433_2211, 64'h0};
    drive_req(32'h0000_1008, 4'b0011, 1'b1, 32'h1122_3344);
    @(negedge clk);  // cycle 1
    checks++; if ({s_cyc, s_stb, s_we} !== 3'b111) begin errors++; $display("FAIL wr_s_ctl got=%b exp=111", {s_cyc, s_stb, s_we}); end
    checks++; if (s_sel !== 16'h0C00) begin errors++; $display("FAIL wr_sel got=%h exp=0c00", s_sel); end
    checks++; if (s_wdat !== exp_wdat) begin errors++; $display("FAIL wr_wdat got=%h exp=%h", s_wdat, exp_wdat); end
    checks++; if (s_adr !== 32'h0000_1008) begin errors++; $display("FAIL wr_adr got=%h exp=00001008", s_adr); end
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_early got=%b exp=0", m_ack); end
    s_ack = 1'b1;
    @(negedge clk);  // cycle 2
    s_ack = 1'b0;
    checks++; if ({m_ack, m_err, s_stb} !== 3'b100) begin errors++; $display("FAIL wr_ack got=%b exp=100", {m_ack, m_err, s_stb}); end
    master_idle();
    @(negedge clk);  // cycle 3
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got=%b exp=0", m_ack); end
  endtask

  task automatic test_read_lanes();
    logic [31:0] exp_rd [4];
    logic [15:0] exp_sel [4];
    exp_rd[0] = 32'hEFBE_ADDE; exp_rd[1] = 32'h8877_6655;
    exp_rd[2] = 32'h0403_0201; exp_rd[3] = 32'hDDCC_BBAA;
    exp_sel[0] = 16'h000F; exp_sel[1] = 16'h00F0; exp_sel[2] = 16'h0F00; exp_sel[3] = 16'hF000;
    s_rdat = {32'hAABB_CCDD, 32'h0102_0304, 32'h5566_7788, 32'hDEAD_BEEF};
    for (int l = 0; l < 4; l++) begin
      drive_req(32'h0000_2000 + 32'(4 * l), 4'hF, 1'b0, 32'h0);
      @(negedge clk);  // cycle 1
      checks++; if (s_sel !== exp_sel[l] || s_we !== 1'b0) begin errors++; $display("FAIL rd_sel lane=%0d got=%h we=%b exp=%h we=0", l, s_sel, s_we, exp_sel[l]); end
      @(negedge clk);  // cycle 2: slave still silent
      checks++; if (s_stb !== 1'b1 || m_ack !== 1'b0) begin errors++; $display("FAIL rd_wait lane=%0d got stb=%b ack=%b exp stb=1 ack=0", l, s_stb, m_ack); end
      s_ack = 1'b1;
      @(negedge clk);  // cycle 3
      s_ack = 1'b0;
      checks++; if (m_ack !== 1'b1 || m_rdat !== exp_rd[l]) begin errors++; $display("FAIL rd_data lane=%0d got ack=%b rdat=%h exp ack=1 rdat=%h", l, m_ack, m_rdat, exp_rd[l]); end
      master_idle();
      @(negedge clk);
    end
  endtask

  task automatic test_ack_err();
    drive_req(32'h0000_5000, 4'hF, 1'b0, 32'h0);
    @(negedge clk);
    s_ack = 1'b1; s_err = 1'b1;
    @(negedge clk);
    s_ack = 1'b0; s_err = 1'b0;
    checks++; if ({m_err, m_ack} !== 2'b10 || m_rdat !== 32'h0) begin errors++; $display("FAIL ackerr got err/ack=%b rdat=%h exp=10 rdat=0", {m_err, m_ack}, m_rdat); end
    master_idle();
    @(negedge clk);
    checks++; if ({m_err, m_ack, s_stb} !== 3'b000) begin errors++; $display("FAIL ackerr_pulse got=%b exp=000", {m_err, m_ack, s_stb}); end
  endtask

  task automatic test_timeout();
    int n;
    drive_req(32'h0000_6000, 4'hF, 1'b0, 32'h0);
    @(negedge clk);
    n = 0;
    while (s_stb === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
`ifdef WB_BRIDGE_TIMEOUT_EN
    checks++; if (n !== 8) begin errors++; $display("FAIL tmo_stb_cycles got=%0d exp=8", n); end
    checks++; if ({tmo, m_err, m_ack} !== 3'b110) begin errors++; $display("FAIL tmo_resp got tmo/err/ack=%b exp=110", {tmo, m_err, m_ack}); end
    master_idle();
    @(negedge clk);
    checks++; if ({tmo, m_err, s_stb} !== 3'b000) begin errors++; $display("FAIL tmo_idle got=%b exp=000", {tmo, m_err, s_stb}); end
`else
    checks++; if (n !== 20 || tmo !== 1'b0) begin errors++; $display("FAIL notmo_wait got cycles=%0d tmo=%b exp cycles=20 tmo=0", n, tmo); end
    s_ack = 1'b1;
    @(negedge clk);
    s_ack = 1'b0;
    checks++; if (m_ack !== 1'b1 || m_err !== 1'b0) begin errors++; $display("FAIL notmo_ack got ack/err=%b%b exp=10", m_ack, m_err); end
    master_idle();
    @(negedge clk);
`endif
  endtask

  task automatic test_abort();
    int bad_stb;
    int resp_seen;
    bad_stb = 0; resp_seen = 0;
    drive_req(32'h0000_4000, 4'hF, 1'b1, 32'hCAFE_F00D);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) master_idle();
      if (s_stb !== 1'b1) bad_stb++;
      if (m_ack === 1'b1 || m_err === 1'b1) resp_seen++;
      if (c == 4) s_ack = 1'b1;
    end
    checks++; if (bad_stb !== 0) begin errors++; $display("FAIL abort_stb_held got_low=%0d exp=0", bad_stb); end
    @(negedge clk);  // cycle 5
    s_ack = 1'b0;
    if (m_ack === 1'b1 || m_err === 1'b1) resp_seen++;
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL abort_stb_drop got=%b exp=0", s_stb); end
    drive_req(32'h0000_4008, 4'hF, 1'b0, 32'h0);
    @(negedge clk);  // cycle 6
    if (m_ack === 1'b1 || m_err === 1'b1) resp_seen++;
    checks++; if (s_stb !== 1'b1) begin errors++; $display("FAIL abort_new_stb got=%b exp=1", s_stb); end
    checks++; if (resp_seen !== 0) begin errors++; $display("FAIL abort_no_resp got=%0d exp=0", resp_seen); end
    s_ack = 1'b1;
    @(negedge clk);  // cycle 7
    s_ack = 1'b0;
    checks++; if (m_ack !== 1'b1 || m_rdat !== 32'h0403_0201) begin errors++; $display("FAIL abort_new_ack got ack=%b rdat=%h exp ack=1 rdat=04030201", m_ack, m_rdat); end
    master_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int resp_seen;
    resp_seen = 0;
    drive_req(32'h0000_7000, 4'hF, 1'b1, 32'h1234_5678);
    @(negedge clk);
    checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%b exp=1", s_cyc); end
    rst_n = 1'b0;
    master_idle();
    #1;
    checks++; if ({s_cyc, s_stb} !== 2'b00) begin errors++; $display("FAIL rstmid_async got=%b exp=00", {s_cyc, s_stb}); end
    @(negedge clk);
    rst_n = 1'b1;
    s_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      s_ack = 1'b0;
      if (m_ack === 1'b1 || m_err === 1'b1 || s_stb === 1'b1) resp_seen++;
    end
    checks++; if (resp_seen !== 0) begin errors++; $display("FAIL rstmid_spurious got=%0d exp=0", resp_seen); end
  endtask

  task automatic test_back_to_back();
    int ack_cyc [2];
    int acks;
    logic [31:0] rd [2];
    acks = 0; ack_cyc[0] = -1; ack_cyc[1] = -1; rd[0] = '0; rd[1] = '0;
    drive_req(32'h0000_3004, 4'hF, 1'b0, 32'h0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      s_ack = s_stb;
      if (m_ack === 1'b1) begin
        if (acks < 2) begin ack_cyc[acks] = c; rd[acks] = m_rdat; end
        acks++;
        if (acks == 1) drive_req(32'h0000_300C, 4'hF, 1'b0, 32'h0);
        else master_idle();
      end
    end
    s_ack = 1'b0;
    checks++; if (acks !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", acks); end
    checks++; if (ack_cyc[0] !== 2 || ack_cyc[1] !== 5) begin errors++; $display("FAIL b2b_timing got=%0d,%0d exp=2,5", ack_cyc[0], ack_cyc[1]); end
    checks++; if (rd[0] !== 32'h8877_6655 || rd[1] !== 32'hDDCC_BBAA) begin errors++; $display("FAIL b2b_data got=%h,%h exp=88776655,ddccbbaa", rd[0], rd[1]); end
    master_idle();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_lane();
    test_read_lanes();
    test_ack_err();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
